// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-add-3 (double dabble) binary to packed BCD converter
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  bin is valid; accepted when in_valid && in_ready
//   in_ready  converter idle and able to accept a word
//   bin       unsigned BIN_W-bit value to convert
//   out_valid bcd/ovf hold a completed result
//   out_ready downstream accepts the result; transfer when out_valid && out_ready
//   bcd       packed BCD result, digit 0 (ones) in bcd[3:0]
//   ovf       value did not fit in DIGITS digits (qualified by out_valid)
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    localparam int CW = $clog2(BIN_W + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BIN_W-1:0]    bin_sr, bin_nx;
    logic [4*DIGITS-1:0] bcd_sr, bcd_adj, bcd_nx;
    logic                ovf_sr, carry;
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign bcd_adj[4*d +: 4] = (bcd_sr[4*d +: 4] >= 4'd5) ? bcd_sr[4*d +: 4] + 4'd3 : bcd_sr[4*d +: 4];
    end
    // the bit leaving the top digit is the overflow carry; it is never fed back
    assign {carry, bcd_nx, bin_nx} = {1'b0, bcd_adj, bin_sr} << 1;
    // bcd/ovf are separate output registers so they hold their value through IDLE
    // and the next conversion, loaded only on the final shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            ovf_sr    <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    bin_sr   <= bin;
                    bcd_sr   <= '0;
                    ovf_sr   <= 1'b0;
                    cnt      <= CW'(BIN_W);
                    in_ready <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    bin_sr <= bin_nx;
                    bcd_sr <= bcd_nx;
                    ovf_sr <= ovf_sr | carry;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd       <= bcd_nx;
                        ovf       <= ovf_sr | carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench for bin_to_bcd_seq (three parameter sets)
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int sel = 0;
    logic iv = 1'b0, ordy = 1'b0;
    logic [15:0] b = '0;
    logic ir_a, ov_a, of_a, ir_b, ov_b, of_b, ir_c, ov_c, of_c;
    logic [11:0] bcd_a;
    logic [19:0] bcd_b;
    logic [7:0]  bcd_c;
    logic ir, ov, of;
    logic [19:0] bcd;
    int bw, nd;
    int n_chk = 0, n_err = 0;
    bin_to_bcd_seq dut_a (.clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 0), .in_ready(ir_a),
        .bin(b[7:0]), .out_valid(ov_a), .out_ready(ordy && sel == 0), .bcd(bcd_a), .ovf(of_a));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_b (.clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 1),
        .in_ready(ir_b), .bin(b), .out_valid(ov_b), .out_ready(ordy && sel == 1), .bcd(bcd_b), .ovf(of_b));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_c (.clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2),
        .in_ready(ir_c), .bin(b[7:0]), .out_valid(ov_c), .out_ready(ordy && sel == 2), .bcd(bcd_c), .ovf(of_c));
    assign ir  = sel == 0 ? ir_a : sel == 1 ? ir_b : ir_c;
    assign ov  = sel == 0 ? ov_a : sel == 1 ? ov_b : ov_c;
    assign of  = sel == 0 ? of_a : sel == 1 ? of_b : of_c;
    assign bcd = sel == 0 ? {8'd0, bcd_a} : sel == 1 ? bcd_b : {12'd0, bcd_c};
    assign bw  = sel == 1 ? 16 : 8;
    assign nd  = sel == 0 ? 3 : sel == 1 ? 5 : 2;
    // reference: decimal digits of v mod 10^n, overflow when v >= 10^n
    function automatic logic [20:0] model(input int v, input int n);
        int p = 1;
        int x;
        logic [19:0] r = '0;
        for (int i = 0; i < n; i++) p *= 10;
        x = v % p;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x /= 10;
        end
        return {v >= p, r};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic start(input int v);
        int t = 0;
        while (!ir && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready", ir, 1);
        b = 16'(v);
        iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        check("busy", ir, 0);
    endtask
    task automatic wait_done(input string tag);
        int edges = 0;
        while (!ov && edges < 40) begin
            @(posedge clk);
            #1 edges++;
        end
        check(tag, edges, bw);
    endtask
    task automatic finish_conv(input int v);
        logic [20:0] e;
        wait_done("latency");
        e = model(v, nd);
        check("bcd", bcd, e[19:0]);
        check("ovf", of, e[20]);
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        check("drain_valid", ov, 0);
        check("drain_ready", ir, 1);
    endtask
    task automatic conv(input int v);
        start(v);
        finish_conv(v);
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ir, 1);
        check("rst_valid", ov, 0);
        check("rst_bcd", bcd, 0);
        check("rst_ovf", of, 0);
        @(negedge clk) rst_n = 1'b1;
        conv(255);
        // back-to-back with in_valid held; bin changes after the first accept
        b = 0; iv = 1'b1; ordy = 1'b1;
        @(posedge clk);
        #1 b = 99;
        check("b2b_busy", ir, 0);
        wait_done("b2b_lat0");
        check("b2b_bcd0", bcd, 20'h000);
        @(posedge clk);
        #1;
        check("b2b_out0", ov, 0);
        check("b2b_idle", ir, 1);
        check("b2b_hold", bcd, 20'h000);
        @(posedge clk);
        #1 iv = 1'b0;
        check("b2b_acc1", ir, 0);
        wait_done("b2b_lat1");
        check("b2b_bcd1", bcd, 20'h099);
        @(posedge clk);
        #1 ordy = 1'b0;
        check("b2b_out1", ov, 0);
        // backpressure with ignored in_valid
        start(150);
        wait_done("bp_lat");
        iv = 1'b1; b = 7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", ov, 1);
            check("bp_bcd", bcd, 20'h150);
            check("bp_ready", ir, 0);
        end
        iv = 1'b0; ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        check("bp_drain", ov, 0);
        // reset in the middle of a conversion
        start(200);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ir, 1);
        check("mid_rst_valid", ov, 0);
        check("mid_rst_bcd", bcd, 0);
        @(negedge clk) rst_n = 1'b1;
        conv(42);
        for (int i = 0; i < 100; i++) conv(int'($urandom_range(0, 255)));
        sel = 1;
        conv(65535);
        conv(0);
        conv(10000);
        conv(9999);
        for (int i = 0; i < 60; i++) conv(int'($urandom_range(0, 65535)));
        sel = 2;
        conv(150);
        conv(99);
        conv(100);
        conv(0);
        conv(255);
        for (int i = 0; i < 40; i++) conv(int'($urandom_range(0, 255)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
